// File: rtl/apu_mixer.sv
// APU output mixer: NR50/NR51/NR52 registers, per-side pan/sum/volume pipeline
// and box-filter decimation to signed 16-bit PCM.
module apu_mixer #(
   parameter int DECIM_LOG2 = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               slow_clk_en,
   input  logic               cpu_en,
   input  logic [2:0]         target,
   input  logic [7:0]         wdata,
   input  logic               write,
   output logic [7:0]         rdata,
   input  logic [3:0]         wave1,
   input  logic [3:0]         wave2,
   input  logic [3:0]         wave3,
   input  logic [3:0]         wave4,
   input  logic [3:0]         ch_active,
   input  logic [3:0]         dac_on,
   output logic               apu_power,
   output logic               apu_clear,
   output logic signed [15:0] left_out,
   output logic signed [15:0] right_out,
   output logic               sample_valid
);

   localparam int AW = 10 + DECIM_LOG2;
   localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);

   function automatic logic signed [6:0] dac_level(input logic en, input logic [3:0] wave);
      logic signed [6:0] v;
      v = $signed({2'b00, wave, 1'b0}) - 7'sd15;
      return en ? v : 7'sd0;
   endfunction

   function automatic logic signed [9:0] scale(input logic signed [6:0] side, input logic [2:0] vol);
      logic signed [9:0] s;
      logic signed [9:0] g;
      s = 10'(side);
      g = $signed({7'b0, vol}) + 10'sd1;
      return s * g;
   endfunction

   logic [7:0]        r_nr50;
   logic [7:0]        r_nr51;
   logic              r_power;
   logic              r_clear;
   logic              w_wr;
   logic signed [6:0] w_dac [4];
   logic signed [6:0] w_mix_l;
   logic signed [6:0] w_mix_r;
   logic signed [6:0] r_mix_l_p0;
   logic signed [6:0] r_mix_r_p0;
   logic signed [9:0] r_side_l_p1;
   logic signed [9:0] r_side_r_p1;
   logic signed [AW-1:0] r_acc_l_p2;
   logic signed [AW-1:0] r_acc_r_p2;
   logic signed [AW-1:0] w_sum_l;
   logic signed [AW-1:0] w_sum_r;
   logic signed [9:0]    w_avg_l;
   logic signed [9:0]    w_avg_r;
   logic [CW-1:0]        r_cnt;

   assign w_wr      = cpu_en & write;
   assign apu_power = r_power;
   assign apu_clear = r_clear;

   // Powering off clears the mixer registers in the same clk as the write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nr50  <= 8'h00;
         r_nr51  <= 8'h00;
         r_power <= 1'b0;
         r_clear <= 1'b1;
      end else begin
         r_clear <= ~r_power;
         if (w_wr & target[2] & r_power & ~wdata[7]) begin
            r_nr50 <= 8'h00;
            r_nr51 <= 8'h00;
         end else begin
            if (w_wr & target[0] & r_power) r_nr50 <= wdata;
            if (w_wr & target[1] & r_power) r_nr51 <= wdata;
         end
         if (w_wr & target[2]) r_power <= wdata[7];
      end
   end

   always_comb begin
      rdata = 8'hFF;
      if (target[0])      rdata = r_nr50;
      else if (target[1]) rdata = r_nr51;
      else if (target[2]) rdata = {r_power, 3'b111, ch_active & {4{r_power}}};
   end

   assign w_dac[0] = dac_level(dac_on[0], wave1);
   assign w_dac[1] = dac_level(dac_on[1], wave2);
   assign w_dac[2] = dac_level(dac_on[2], wave3);
   assign w_dac[3] = dac_level(dac_on[3], wave4);

   always_comb begin
      w_mix_l = 7'sd0;
      w_mix_r = 7'sd0;
      if (r_power) begin
         for (int n = 0; n < 4; n++) begin
            if (r_nr51[4+n]) w_mix_l = w_mix_l + w_dac[n];
            if (r_nr51[n])   w_mix_r = w_mix_r + w_dac[n];
         end
      end
   end

   assign w_sum_l = r_acc_l_p2 + AW'(r_side_l_p1);
   assign w_sum_r = r_acc_r_p2 + AW'(r_side_r_p1);
   assign w_avg_l = 10'(w_sum_l >>> DECIM_LOG2);
   assign w_avg_r = 10'(w_sum_r >>> DECIM_LOG2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mix_l_p0   <= '0;
         r_mix_r_p0   <= '0;
         r_side_l_p1  <= '0;
         r_side_r_p1  <= '0;
         r_acc_l_p2   <= '0;
         r_acc_r_p2   <= '0;
         r_cnt        <= '0;
         left_out     <= '0;
         right_out    <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (slow_clk_en) begin
            // p0: panned channel sum
            r_mix_l_p0  <= w_mix_l;
            r_mix_r_p0  <= w_mix_r;
            // p1: master volume
            r_side_l_p1 <= scale(r_mix_l_p0, r_nr50[6:4]);
            r_side_r_p1 <= scale(r_mix_r_p0, r_nr50[2:0]);
            // p2: window accumulate / emit
            if (r_cnt == LAST) begin
               r_cnt        <= '0;
               r_acc_l_p2   <= '0;
               r_acc_r_p2   <= '0;
               left_out     <= {w_avg_l, 6'b0};
               right_out    <= {w_avg_r, 6'b0};
               sample_valid <= 1'b1;
            end else begin
               r_cnt      <= r_cnt + CW'(1);
               r_acc_l_p2 <= w_sum_l;
               r_acc_r_p2 <= w_sum_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_apu_mixer.sv
// Bench for apu_mixer: three decimation settings share stimulus; a tick-level
// reference model feeds per-instance sample queues, plus table-driven steady-state vectors.
module tb_apu_mixer;

   logic clk = 1'b0;
   logic reset, slow_clk_en, cpu_en, write;
   logic [2:0] target;
   logic [7:0] wdata;
   logic [3:0] wave1, wave2, wave3, wave4, ch_active, dac_on;

   logic [7:0] rd2, rd1, rd0;
   logic pw2, pw1, pw0, clr2, clr1, clr0, v2, v1, v0;
   logic signed [15:0] l2, r2, l1, r1, l0, r0;

   always #5 clk = ~clk;

   apu_mixer #(.DECIM_LOG2(2)) u2 (.clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
      .target(target), .wdata(wdata), .write(write), .rdata(rd2), .wave1(wave1), .wave2(wave2),
      .wave3(wave3), .wave4(wave4), .ch_active(ch_active), .dac_on(dac_on), .apu_power(pw2),
      .apu_clear(clr2), .left_out(l2), .right_out(r2), .sample_valid(v2));
   apu_mixer #(.DECIM_LOG2(1)) u1 (.clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
      .target(target), .wdata(wdata), .write(write), .rdata(rd1), .wave1(wave1), .wave2(wave2),
      .wave3(wave3), .wave4(wave4), .ch_active(ch_active), .dac_on(dac_on), .apu_power(pw1),
      .apu_clear(clr1), .left_out(l1), .right_out(r1), .sample_valid(v1));
   apu_mixer #(.DECIM_LOG2(0)) u0 (.clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
      .target(target), .wdata(wdata), .write(write), .rdata(rd0), .wave1(wave1), .wave2(wave2),
      .wave3(wave3), .wave4(wave4), .ch_active(ch_active), .dac_on(dac_on), .apu_power(pw0),
      .apu_clear(clr0), .left_out(l0), .right_out(r0), .sample_valid(v0));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model state
   typedef struct { int l; int r; } samp_t;
   samp_t q0[$], q1[$], q2[$];
   int Lh[4096], Rh[4096], GLh[4096], GRh[4096];
   int tcount;
   logic [7:0] m50, m51;
   bit mpw;
   int lastL2, lastR2, lastL1, lastR1;

   function automatic int sbL(int j);
      return (j >= 2) ? Lh[j-2] * GLh[j-1] : 0;
   endfunction
   function automatic int sbR(int j);
      return (j >= 2) ? Rh[j-2] * GRh[j-1] : 0;
   endfunction

   task automatic model_reset();
      q0.delete(); q1.delete(); q2.delete();
      tcount = 0; m50 = 8'h00; m51 = 8'h00; mpw = 1'b0;
      lastL2 = 0; lastR2 = 0; lastL1 = 0; lastR1 = 0;
   endtask

   task automatic model_tick();
      logic [3:0] w [4];
      int l, r, d, dec, sl, sr;
      samp_t s;
      w[0] = wave1; w[1] = wave2; w[2] = wave3; w[3] = wave4;
      l = 0; r = 0;
      for (int n = 0; n < 4; n++) begin
         d = dac_on[n] ? (2 * int'(w[n]) - 15) : 0;
         if (mpw && m51[4+n]) l += d;
         if (mpw && m51[n])   r += d;
      end
      Lh[tcount] = l; Rh[tcount] = r;
      GLh[tcount] = int'(m50[6:4]) + 1;
      GRh[tcount] = int'(m50[2:0]) + 1;
      for (int k = 0; k < 3; k++) begin
         dec = 1 << k;
         if (((tcount + 1) % dec) == 0) begin
            sl = 0; sr = 0;
            for (int j = tcount - dec + 1; j <= tcount; j++) begin
               sl += sbL(j); sr += sbR(j);
            end
            s.l = (sl >>> k) * 64;
            s.r = (sr >>> k) * 64;
            if (k == 0) q0.push_back(s);
            else if (k == 1) q1.push_back(s);
            else q2.push_back(s);
         end
      end
      tcount++;
   endtask

   task automatic model_write(input logic [2:0] tgt, input logic [7:0] d);
      bit old;
      old = mpw;
      if (tgt[2]) begin
         if (old && !d[7]) begin m50 = 8'h00; m51 = 8'h00; end
         mpw = d[7];
      end
      if (tgt[0] && old) m50 = d;
      if (tgt[1] && old) m51 = d;
   endtask

   // One clk: optional tick and/or write; returns at posedge+1
   task automatic cyc(input bit tk, input bit wr, input logic [2:0] tgt, input logic [7:0] d, input bit en);
      @(negedge clk);
      slow_clk_en = tk; write = wr; target = tgt; wdata = d; cpu_en = en;
      if (tk) model_tick();
      if (wr && en) model_write(tgt, d);
      @(posedge clk); #1;
      slow_clk_en = 1'b0; write = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, target, 8'h00, 1'b1);
   endtask

   task automatic wr(input logic [2:0] tgt, input logic [7:0] d);
      cyc(1'b0, 1'b1, tgt, d, 1'b1);
   endtask

   task automatic rd_check(input string name, input logic [2:0] tgt, input int exp);
      target = tgt; #1;
      check(name, int'(rd2), exp);
   endtask

   // Scoreboard: pop expected sample whenever an instance strobes valid
   always @(negedge clk) begin
      samp_t e;
      if (!reset) begin
         if (v2) begin
            check("u2_sample_expected", int'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
               e = q2.pop_front();
               check("u2_left", int'(l2), e.l); check("u2_right", int'(r2), e.r);
            end
            lastL2 = int'(l2); lastR2 = int'(r2);
         end
         if (v1) begin
            check("u1_sample_expected", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
               e = q1.pop_front();
               check("u1_left", int'(l1), e.l); check("u1_right", int'(r1), e.r);
            end
            lastL1 = int'(l1); lastR1 = int'(r1);
         end
         if (v0) begin
            check("u0_sample_expected", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
               e = q0.pop_front();
               check("u0_left", int'(l0), e.l); check("u0_right", int'(r0), e.r);
            end
         end
      end
   end

   typedef struct {
      logic [7:0] nr50, nr51;
      logic [3:0] w1, w2, w3, w4, dac;
      int expL, expR;
   } vec_t;
   vec_t vt[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'h77, 8'h11, 4'd15, 4'd0,  4'd0,  4'd0,  4'b0001,  7680,  7680};
      vt[1] = '{8'h70, 8'h10, 4'd0,  4'd0,  4'd0,  4'd0,  4'b0001, -7680,     0};
      vt[2] = '{8'h77, 8'hFF, 4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 30720, 30720};
      vt[3] = '{8'h00, 8'h11, 4'd15, 4'd0,  4'd0,  4'd0,  4'b0001,   960,   960};
      vt[4] = '{8'h32, 8'h21, 4'd10, 4'd3,  4'd0,  4'd0,  4'b0011, -2304,   960};
      vt[5] = '{8'h77, 8'hFF, 4'd15, 4'd15, 4'd15, 4'd15, 4'b0000,     0,     0};

      reset = 1'b1; slow_clk_en = 1'b0; cpu_en = 1'b0; write = 1'b0;
      target = 3'b000; wdata = 8'h00; ch_active = 4'b1010; dac_on = 4'b0000;
      wave1 = 4'd0; wave2 = 4'd0; wave3 = 4'd0; wave4 = 4'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_left", int'(l2), 0); check("rst_right", int'(r2), 0);
      check("rst_valid", int'(v2), 0); check("rst_power", int'(pw2), 0);
      check("rst_clear", int'(clr2), 1);
      reset = 1'b0;

      rd_check("rst_nr50", 3'b001, 8'h00);
      rd_check("rst_nr51", 3'b010, 8'h00);
      rd_check("rst_nr52", 3'b100, 8'h70);
      rd_check("no_target", 3'b000, 8'hFF);
      wr(3'b001, 8'h77);
      rd_check("nr50_off_ignored", 3'b001, 8'h00);
      ticks(8);

      // Power on; apu_clear falls one clk later
      wr(3'b100, 8'h80);
      check("power_on", int'(pw2), 1);
      check("clear_still_high", int'(clr2), 1);
      cyc(1'b0, 1'b0, 3'b100, 8'h00, 1'b1);
      check("clear_fell", int'(clr2), 0);
      rd_check("nr52_on", 3'b100, 8'hFA);

      for (int i = 0; i < 6; i++) begin
         wr(3'b001, vt[i].nr50);
         wr(3'b010, vt[i].nr51);
         rd_check($sformatf("vec%0d_nr51", i), 3'b010, int'(vt[i].nr51));
         wave1 = vt[i].w1; wave2 = vt[i].w2; wave3 = vt[i].w3; wave4 = vt[i].w4;
         dac_on = vt[i].dac;
         ticks(12);
         check($sformatf("vec%0d_left", i), lastL2, vt[i].expL);
         check($sformatf("vec%0d_right", i), lastR2, vt[i].expR);
      end

      // Alternating +15/-15 averages to zero over a 2-tick window
      wr(3'b001, 8'h00); wr(3'b010, 8'h11);
      dac_on = 4'b0001; wave2 = 4'd0; wave3 = 4'd0; wave4 = 4'd0;
      for (int i = 0; i < 16; i++) begin
         wave1 = (i % 2 == 0) ? 4'd15 : 4'd0;
         ticks(1);
      end
      check("alt_u1_left", lastL1, 0);
      check("alt_u1_right", lastR1, 0);

      // Write landing on a tick: datapath sees old NR50
      wave1 = 4'd15;
      ticks(3);
      cyc(1'b1, 1'b1, 3'b001, 8'h77, 1'b1);
      ticks(9);
      check("wr_tick_left", lastL2, 7680);

      // Write without cpu_en is ignored
      cyc(1'b0, 1'b1, 3'b001, 8'h55, 1'b0);
      rd_check("cpu_en_gate", 3'b001, 8'h77);

      // Mid-window power-off
      wr(3'b010, 8'hFF);
      wave1 = 4'd15; wave2 = 4'd15; wave3 = 4'd15; wave4 = 4'd15;
      dac_on = 4'b1111; ch_active = 4'b1111;
      ticks(11);
      wr(3'b100, 8'h00);
      check("off_clear_not_yet", int'(clr2), 0);
      rd_check("off_nr52", 3'b100, 8'h70);
      rd_check("off_nr50_cleared", 3'b001, 8'h00);
      rd_check("off_nr51_cleared", 3'b010, 8'h00);
      cyc(1'b0, 1'b0, 3'b010, 8'h00, 1'b1);
      check("off_clear_rose", int'(clr2), 1);
      ticks(12);
      check("off_decay_left", lastL2, 0);
      check("off_decay_right", lastR2, 0);

      // Reset in the middle of a window
      wr(3'b100, 8'h80); wr(3'b001, 8'h77); wr(3'b010, 8'hFF);
      ticks(10);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      check("midrst_left", int'(l2), 0); check("midrst_valid", int'(v2), 0);
      check("midrst_u1_left", int'(l1), 0);
      check("midrst_clear", int'(clr2), 1);
      rd_check("midrst_nr50", 3'b001, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      wr(3'b100, 8'h80); wr(3'b001, 8'h77); wr(3'b010, 8'h11);
      dac_on = 4'b0001;
      ticks(14);
      check("post_rst_left", lastL2, 7680);

      repeat (3) cyc(1'b0, 1'b0, 3'b000, 8'h00, 1'b1);
      check("q2_drained", q2.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("q0_drained", q0.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apu_mixer.md
Name: apu_mixer

Overview:
Downstream stage of the four APU tone/noise/wave channels. It owns the NR50 (master volume), NR51 (panning) and NR52 (power/status) registers, converts each channel's 4-bit wave to a signed DAC level, pans, sums and volume-scales per side, and box-filter decimates to signed 16-bit PCM with a valid strobe. It also drives the APU-wide power-off clear to the channels.

Parameters:
DECIM_LOG2, 5, log2 of the number of slow_clk_en ticks averaged per output sample (DECIM = 2^DECIM_LOG2); legal range 0..8.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
slow_clk_en  in  1  APU tick enable; the datapath advances only on this tick
cpu_en  in  1  CPU bus phase enable; register writes are accepted only when this is high
target  in  3  one-hot register select: [0]=NR50, [1]=NR51, [2]=NR52
wdata  in  8  write data
write  in  1  write strobe
rdata  out  8  read data for the selected register
wave1..wave4  in  4 each  channel wave outputs
ch_active  in  4  per-channel length_play (bit n-1 = channel n)
dac_on  in  4  per-channel DAC enable (envelope/NR30 nonzero)
apu_power  out  1  NR52 bit7
apu_clear  out  1  high while power is off; channels hold their registers cleared
left_out  out  16  signed left PCM sample
right_out  out  16  signed right PCM sample
sample_valid  out  1  one-clk pulse when left_out/right_out update

Behaviour:
- Reset: NR50=0x00, NR51=0x00, power=0, apu_clear=1, left_out=right_out=0, sample_valid=0, all pipeline registers, accumulators and tick counter = 0.
- Write: accepted when cpu_en & write & target[n]. NR52 accepts only wdata[7]. While power=0, NR50/NR51 writes are ignored.
- Power 1->0 on an NR52 write: NR50 and NR51 are cleared to 0x00 in the same clk; apu_clear rises the next clk. Power 0->1: apu_clear falls the next clk. Accumulators are not cleared.
- Reads (combinational): NR50 -> full byte; NR51 -> full byte; NR52 -> {power, 3'b111, ch_active & {4{power}}}; no target bit -> 0xFF.
- Datapath: every stage advances only on slow_clk_en.
  - S1: dac_n = dac_on[n] ? (2*wave_n - 15) : 0, a 5-bit signed value in -15..+15. L = sum of dac_n where NR51[4+n-1]; R = sum where NR51[n-1]. Each side is 7-bit signed, range -60..+60. Registered.
  - S2: sideL = L*(NR50[6:4]+1), sideR = R*(NR50[2:0]+1), 10-bit signed, range -480..+480. Registered. NR50[7] and NR50[3] (VIN) are stored but unused.
  - S3: accumulators add S2 each tick, width 10+DECIM_LOG2 signed. A tick counter counts 0..DECIM-1.
  - On the tick where the counter = DECIM-1: out = ((acc + S2) >>> DECIM_LOG2) <<< 6, i.e. the arithmetic-shift average, sign-extended to 16 bits. Range is -30720..+30720, so it never saturates. Outputs register; sample_valid pulses one clk; accumulators reload 0; counter wraps to 0.
- Latency: a channel change reaches S2 after 2 ticks. An output sample covers the S2 values of the DECIM ticks ending with its valid tick.
- Power=0: S1 forces L=R=0, so output decays to 0 after the pipeline plus one full window. sample_valid keeps pulsing every DECIM ticks.
- Simultaneous write and tick: the datapath uses the pre-write register values in that clk.
- DECIM_LOG2=0: every tick produces a sample, and the output is S2<<6.
- Reset mid-window: everything returns to reset values; no partial sample is emitted.

Test Plan:
- Reset, then read all registers -> NR50=0x00, NR51=0x00, NR52=0x70 (power=0, ch_active masked); apu_clear=1; no writes to NR50 accepted (write 0x77, read back 0x00).
- Power on (NR52=0x80), NR50=0x77, NR51=0x11, wave1=15, dac_on=0001, DECIM_LOG2=2 -> after pipeline fill, left=right=15*8<<6=7680; sample_valid pulses every 4 ticks.
- NR51=0x10, wave1=0, dac_on[0]=1, NR50=0x70 -> left=(-15*8)<<6=-7680, right=0.
- All four channels at wave=15, dac on, NR51=0xFF, NR50=0x77 -> left=right=30720; no overflow.
- Alternate wave1 between 15 and 0 every tick, DECIM_LOG2=1, NR50=0x00, NR51=0x11 -> average of +15 and -15 = 0 -> output 0.
- Mid-window power-off write -> same clk NR50/NR51 read 0x00, apu_clear=1 next clk; ch_active=1111 reads NR52=0x70; the next full window yields 0.
